// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and types for the SPI responder.
//   MODE0..MODE3       : {CPOL, CPHA} encodings of the four SPI modes
//   CPOL_BIT, CPHA_BIT : bit positions inside the 2-bit mode field
//   spi_state_t        : IDLE / ACTIVE link states
//   IDLE_WORD          : all-ones word sent when no transmit data is pending
package spi_pkg;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

    // Wide enough for any practical word length; users slice the low bits.
    localparam logic [63:0] IDLE_WORD = '1;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for an asynchronous pin, followed by
// rise/fall edge detection in the clk domain.
//   clk, rst : system clock, asynchronous active-low reset
//   din      : asynchronous input pin
//   rise     : one-cycle pulse on a synchronised 0->1 transition
//   fall     : one-cycle pulse on a synchronised 1->0 transition
// INIT sets the reset level so an idle-high pin (e.g. ss) does not produce a
// spurious edge when reset is released.
module spi_sync_edge #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= {STAGES{INIT}};
            prev_reg <= INIT;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], din};
            prev_reg <= sync_reg[STAGES-1];
        end
    end

    assign rise = sync_reg[STAGES-1] & ~prev_reg;
    assign fall = ~sync_reg[STAGES-1] & prev_reg;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: clock-oversampled SPI responder, all four modes, MSB/LSB first.
//   clk, rst             : system clock (>= 8x SCK), asynchronous active-low reset
//   sck, ss, mosi, miso  : SPI pins (ss active-low); miso_oe enables the miso pad
//   mode, lsbfirst       : {CPOL,CPHA} and bit order, latched when selected
//   tx_data, tx_wr       : write port of the one-word transmit holding buffer
//   tx_ready             : holding buffer empty
//   rx_data, rx_valid    : last complete received word, one-cycle update strobe
//   busy                 : high while selected
//   overrun              : sticky error flag, only when SPI_SLAVE_OVERRUN_EN is defined
module spi_slave
    import spi_pkg::*;
#(
    parameter int WORD_LEN    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sck,
    input  logic                ss,
    input  logic                mosi,
    output logic                miso,
    output logic                miso_oe,
    input  logic [1:0]          mode,
    input  logic                lsbfirst,
    input  logic [WORD_LEN-1:0] tx_data,
    input  logic                tx_wr,
    output logic                tx_ready,
    output logic [WORD_LEN-1:0] rx_data,
    output logic                rx_valid,
    output logic                busy
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    output logic                overrun
`endif
);

    localparam int CNT_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_LEN - 1);

    logic sck_rise, sck_fall, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sck_sync (
        .clk(clk), .rst(rst), .din(sck), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ss_sync (
        .clk(clk), .rst(rst), .din(ss), .rise(ss_rise), .fall(ss_fall)
    );

    // mosi only needs to be sampled, so it gets the bare synchroniser; it
    // shares the sck pipeline depth so data and clock stay aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mosi_sync_reg <= '0;
        else      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
    end

    spi_state_t          state_reg, state_next;
    logic                cpol_reg, cpha_reg, lsb_reg;
    logic [CNT_W-1:0]    bit_cnt_reg;
    logic [WORD_LEN-1:0] tx_shift_reg, rx_shift_reg, rx_data_reg;
    logic [WORD_LEN-1:0] hold_reg;
    logic                hold_full_reg;
    logic                miso_reg, miso_oe_reg, rx_valid_reg;

    logic                start, stop, lead, trail, sample_en, shift_en, word_done;
    logic                mosi_s;
    logic [WORD_LEN-1:0] load_word, rx_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= ST_IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (ss_fall) state_next = ST_ACTIVE;
            ST_ACTIVE: if (ss_rise) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign start     = (state_reg == ST_IDLE) && ss_fall;
    assign stop      = (state_reg == ST_ACTIVE) && ss_rise;
    assign lead      = cpol_reg ? sck_fall : sck_rise;
    assign trail     = cpol_reg ? sck_rise : sck_fall;
    assign sample_en = (state_reg == ST_ACTIVE) && !ss_rise && (cpha_reg ? trail : lead);
    assign shift_en  = (state_reg == ST_ACTIVE) && !ss_rise && (cpha_reg ? lead : trail);
    assign word_done = sample_en && (bit_cnt_reg == LAST_BIT);
    assign load_word = hold_full_reg ? hold_reg : IDLE_WORD[WORD_LEN-1:0];
    assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
    assign rx_next   = lsb_reg ? {mosi_s, rx_shift_reg[WORD_LEN-1:1]}
                               : {rx_shift_reg[WORD_LEN-2:0], mosi_s};

    // tx_shift_reg holds the bits not yet driven onto miso: each shift edge
    // drives the next bit and consumes it. For CPHA=0 the first bit is driven
    // at select, so the loaded word is stored already consumed by one bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpol_reg     <= 1'b0;
            cpha_reg     <= 1'b0;
            lsb_reg      <= 1'b0;
            bit_cnt_reg  <= '0;
            tx_shift_reg <= '1;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            miso_reg     <= 1'b1;
            miso_oe_reg  <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            if (start) begin
                cpol_reg    <= mode[CPOL_BIT];
                cpha_reg    <= mode[CPHA_BIT];
                lsb_reg     <= lsbfirst;
                bit_cnt_reg <= '0;
                miso_oe_reg <= 1'b1;
                if (!mode[CPHA_BIT]) begin
                    miso_reg     <= lsbfirst ? load_word[0] : load_word[WORD_LEN-1];
                    tx_shift_reg <= lsbfirst ? (load_word >> 1) : (load_word << 1);
                end else begin
                    tx_shift_reg <= load_word;
                end
            end else if (stop) begin
                bit_cnt_reg <= '0;
                miso_oe_reg <= 1'b0;
                miso_reg    <= 1'b1;
            end else begin
                if (shift_en) begin
                    miso_reg     <= lsb_reg ? tx_shift_reg[0] : tx_shift_reg[WORD_LEN-1];
                    tx_shift_reg <= lsb_reg ? (tx_shift_reg >> 1) : (tx_shift_reg << 1);
                end
                if (sample_en) begin
                    if (word_done) begin
                        rx_data_reg  <= rx_next;
                        rx_valid_reg <= 1'b1;
                        bit_cnt_reg  <= '0;
                        tx_shift_reg <= load_word;
                    end else begin
                        rx_shift_reg <= rx_next;
                        bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                    end
                end
            end
        end
    end

    // Holding buffer: a reload empties it; a write is accepted only when it
    // was empty at the start of the cycle, so a write coinciding with a reload
    // of an empty buffer refills it while the reload takes all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
        end else if ((start || word_done) && hold_full_reg) begin
            hold_full_reg <= 1'b0;
        end else if (tx_wr && !hold_full_reg) begin
            hold_reg      <= tx_data;
            hold_full_reg <= 1'b1;
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic empty_load_reg;
    logic overrun_reg;

    // empty_load_reg remembers that the word currently shifting out is the
    // all-ones filler; the error is flagged when that word completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            empty_load_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            if (start || word_done) empty_load_reg <= !hold_full_reg;
            if ((word_done && empty_load_reg) || (tx_wr && hold_full_reg))
                overrun_reg <= 1'b1;
        end
    end

    assign overrun = overrun_reg;
`endif

    assign miso     = miso_reg;
    assign miso_oe  = miso_oe_reg;
    assign tx_ready = !hold_full_reg;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign busy     = (state_reg == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed-vector bench for spi_slave acting as the SPI master.
// Covers reset, all four modes, both bit orders, back-to-back words, empty
// holding buffer, aborted words, mid-word reset and ignored buffer writes.
// Build with SPI_SLAVE_OVERRUN_EN defined to also check the overrun flag.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sck = 1'b0;
    logic       ss = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe;
    logic [1:0] mode = 2'b00;
    logic       lsbfirst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic       overrun;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int rx_cnt = 0;
    logic [7:0] last_rx = 8'h00;
    logic [7:0] got;

    spi_slave #(.WORD_LEN(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sck(sck), .ss(ss), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .mode(mode), .lsbfirst(lsbfirst),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
`ifdef SPI_SLAVE_OVERRUN_EN
        , .overrun(overrun)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt  <= rx_cnt + 1;
            last_rx <= rx_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end else begin
            $display("ok   %s: 0x%0h", tag, actual);
        end
    endtask

    task automatic write_tx(input logic [7:0] v);
        @(negedge clk);
        tx_data = v;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr   = 1'b0;
    endtask

    // Sets mode pins and sck idle level while deselected, then selects.
    task automatic select(input logic [1:0] m, input logic lsb);
        @(negedge clk);
        mode     = m;
        lsbfirst = lsb;
        sck      = m[1];
        #100;
        ss = 1'b0;
        #160;
    endtask

    task automatic deselect();
        #80;
        ss = 1'b1;
        #160;
    endtask

    // Master side of nbits of a word; SCK half-period is 8 clk cycles.
    task automatic xfer(input logic [7:0] txw, input int nbits, output logic [7:0] rxw);
        int idx;
        rxw = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            idx = lsbfirst ? i : 7 - i;
            if (!mode[0]) begin
                mosi = txw[idx];
                #80 sck = ~mode[1];
                rxw[idx] = miso;
                #80 sck = mode[1];
            end else begin
                sck  = ~mode[1];
                mosi = txw[idx];
                #80 sck = mode[1];
                rxw[idx] = miso;
                #80;
            end
        end
    endtask

    initial begin
        #20;
        @(negedge clk);
        check("rst_miso", miso, 1);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        #50;

        // Mode 0, MSB first
        write_tx(8'h3C);
        check("m0_tx_ready_full", tx_ready, 0);
        select(2'b00, 1'b0);
        check("m0_tx_ready_sel", tx_ready, 1);
        check("m0_busy", busy, 1);
        check("m0_miso_oe", miso_oe, 1);
        xfer(8'hA5, 8, got);
        deselect();
        check("m0_miso_word", got, 8'h3C);
        check("m0_rx_data", last_rx, 8'hA5);
        check("m0_rx_cnt", rx_cnt, 1);
        check("m0_oe_off", miso_oe, 0);
        check("m0_miso_idle", miso, 1);
`ifdef SPI_SLAVE_OVERRUN_EN
        check("m0_overrun", overrun, 0);
`endif

        // Mode 3, LSB first, back-to-back words
        write_tx(8'h55);
        select(2'b11, 1'b1);
        write_tx(8'hAA);
        xfer(8'h81, 8, got);
        check("m3_w1_miso", got, 8'h55);
        check("m3_w1_rx", last_rx, 8'h81);
        xfer(8'h7E, 8, got);
        deselect();
        check("m3_w2_miso", got, 8'hAA);
        check("m3_w2_rx", last_rx, 8'h7E);
        check("m3_rx_cnt", rx_cnt, 3);
`ifdef SPI_SLAVE_OVERRUN_EN
        check("m3_overrun", overrun, 0);
`endif

        // Mode 1, empty buffer
        select(2'b01, 1'b0);
        xfer(8'h12, 8, got);
        deselect();
        check("m1_miso_ones", got, 8'hFF);
        check("m1_rx", last_rx, 8'h12);
`ifdef SPI_SLAVE_OVERRUN_EN
        check("m1_overrun", overrun, 1);
`endif

        // Aborted word after 5 bits
        select(2'b00, 1'b0);
        xfer(8'hC3, 5, got);
        deselect();
        check("abort_rx_cnt", rx_cnt, 4);
        check("abort_rx_data", rx_data, 8'h12);
        check("abort_oe", miso_oe, 0);
        write_tx(8'h96);
        select(2'b00, 1'b0);
        xfer(8'h3D, 8, got);
        deselect();
        check("after_abort_rx", last_rx, 8'h3D);
        check("after_abort_miso", got, 8'h96);

        // Mode 2, reset mid-word
        write_tx(8'h0F);
        select(2'b10, 1'b0);
        xfer(8'hF0, 4, got);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_miso", miso, 1);
        check("mid_rst_oe", miso_oe, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_tx_ready", tx_ready, 1);
        check("mid_rst_rx_data", rx_data, 8'h00);
        check("mid_rst_rx_valid", rx_valid, 0);
`ifdef SPI_SLAVE_OVERRUN_EN
        check("mid_rst_overrun", overrun, 0);
`endif
        #9;
        ss = 1'b1;
        #40;
        rst = 1'b1;
        #40;
        write_tx(8'hC7);
        select(2'b10, 1'b0);
        xfer(8'h5A, 8, got);
        deselect();
        check("m2_rx", last_rx, 8'h5A);
        check("m2_miso", got, 8'hC7);
        check("m2_rx_cnt", rx_cnt, 6);

        // Write with buffer full is ignored
        write_tx(8'h11);
        write_tx(8'h22);
        check("wr_full_ready", tx_ready, 0);
        select(2'b00, 1'b0);
        xfer(8'h00, 8, got);
        deselect();
        check("wr_full_keep", got, 8'h11);
`ifdef SPI_SLAVE_OVERRUN_EN
        check("wr_full_overrun", overrun, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

Clock-oversampled SPI responder: the far end of the team's SPI master, for bench loopback and FPGA-to-FPGA links. SCK, SS and MOSI are synchronised into `clk` and edge-detected. Words are shifted in and out in all four SPI modes, MSB- or LSB-first. The user side has a one-word transmit holding buffer and a one-cycle receive strobe.

## Interface
- `WORD_LEN`, 8: bits per word.
- `SYNC_STAGES`, 2: synchroniser flops on `sck`, `ss`, `mosi` (≥2).
- `clk` in 1: system clock; must be ≥8× SCK frequency.
- `rst` in 1: reset, asynchronous, active-low.
- `sck` in 1: SPI clock from master.
- `ss` in 1: slave select, active-low.
- `mosi` in 1: serial data in.
- `miso` out 1: serial data out.
- `miso_oe` out 1: output enable for `miso` pad; high only while selected.
- `mode` in 2: {CPOL, CPHA}; latched at select.
- `lsbfirst` in 1: 0 = MSB first, 1 = LSB first; latched at select.
- `tx_data` in WORD_LEN: next word to transmit.
- `tx_wr` in 1: write strobe for `tx_data`.
- `tx_ready` out 1: holding buffer empty.
- `rx_data` out WORD_LEN: last complete received word.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `busy` out 1: high while selected.
- `overrun` out 1: sticky; present only with the macro below.

## Operation
- Reset values: `miso`=1, `miso_oe`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `busy`=0, `overrun`=0. State IDLE, bit count 0.
- States: IDLE, ACTIVE.
- IDLE→ACTIVE on a synchronised `ss` falling edge. On that transition:
  - latch `mode` and `lsbfirst`;
  - load the shift-out register from the holding buffer if it is full and set `tx_ready`=1; if it is empty, load all-ones;
  - assert `miso_oe`;
  - for CPHA=0, drive the first bit onto `miso`.
- ACTIVE→IDLE on a synchronised `ss` rising edge, from any bit count:
  - a partial word is discarded; no `rx_valid`;
  - bit count clears; `miso_oe`=0; `miso`=1.
- Edges: the leading edge is rising if CPOL=0, falling if CPOL=1.
  - CPHA=0: sample on leading, shift on trailing.
  - CPHA=1: shift on leading, sample on trailing.
- Bit order: MSB-first sends and receives bit WORD_LEN-1 first; LSB-first uses bit 0 first.
- On the WORD_LEN-th sample:
  - `rx_data` takes the assembled word; `rx_valid` pulses;
  - bit count wraps to 0;
  - the shift-out register reloads per the select rule above, for back-to-back words with SS held low.
- Holding buffer: `tx_wr` with `tx_ready`=1 captures `tx_data` and drops `tx_ready` next cycle. `tx_wr` with `tx_ready`=0 is ignored.
- Simultaneous `tx_wr` and reload in the same cycle: the reload takes the old buffer (or all-ones if it was empty), and the write fills the buffer.
- SCK edges while IDLE are ignored.

## Timing
- Edge detection latency: SYNC_STAGES+1 `clk` cycles after a pin edge.
- `miso` updates SYNC_STAGES+2 cycles after the shifting SCK edge. The ≥8× clock ratio keeps this inside the half-period.
- `rx_valid` asserts SYNC_STAGES+2 cycles after the final sampling edge.
- `mosi` is sampled from its synchronised copy in the same cycle the edge is detected.
- Reset asserted mid-word: immediate return to reset values; no partial `rx_valid`.

## Configuration
- `SPI_SLAVE_OVERRUN_EN` defined:
  - `overrun` port exists;
  - set when a word completes with the holding buffer empty (all-ones was sent), or when `tx_wr` arrives with `tx_ready`=0;
  - cleared only by reset.
- Undefined: port absent; those events are silently ignored.

## Structure
- Shared package `spi_pkg`: mode encodings (MODE0..MODE3), CPOL/CPHA bit indices, IDLE/ACTIVE state constants, all-ones idle-word constant.
- One sub-module, `spi_sync_edge`: SYNC_STAGES synchroniser plus rise/fall pulse outputs; instantiated for `sck` and `ss`; `mosi` uses the bare synchroniser.

## Test plan
- Mode 0, MSB-first, `tx_data`=0x3C preloaded; master sends 0xA5 → `miso` bits 0,0,1,1,1,1,0,0; `rx_data`=0xA5; one `rx_valid` pulse; `tx_ready`=1 after select.
- Mode 3, LSB-first; master sends 0x81 then 0x7E with SS held low, `tx_data` 0x55 then 0xAA written between words → `rx_valid` twice with 0x81, 0x7E; master receives 0x55, 0xAA.
- Holding buffer empty at select, mode 1 → slave sends 0xFF. With the macro, `overrun`=1 after the word.
- SS deasserted after 5 bits of 0xC3 → no `rx_valid`, `rx_data` unchanged, `miso_oe`=0, next select starts at bit 0.
- `rst` low mid-word in mode 2 → all outputs at reset values within one cycle; subsequent transfer of 0x5A received correctly.
- `tx_wr` with `tx_ready`=0 → buffer keeps its first value. With the macro, `overrun`=1; without it, no flag.
